// File: rtl/bd_dn_arbiter.sv
// bd_dn_arbiter: round-robin, packet-atomic merge of NUM_IN downstream word
// channels onto the single registered BD downstream channel.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no message in flight; scan in_valid starting at ptr
// LOCKED  | mid-message; only requester gnt is served until it sends last
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_last [NUM_IN], in_data [NUM_IN*N] (req i at i*N)
//   out_valid/out_ready, out_data [N], out_src [SW], out_last
//   busy : LOCKED or output register occupied
module bd_dn_arbiter #(
  parameter int NUM_IN = 4,
  parameter int N      = 21,
  parameter int SW     = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] in_valid,
  output logic [NUM_IN-1:0] in_ready,
  input  logic [NUM_IN*N-1:0] in_data,
  input  logic [NUM_IN-1:0] in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [SW-1:0]     out_src,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] gnt_q, gnt_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_src_q, out_src_d;
  logic          out_last_q, out_last_d;

  logic          load;
  logic [SW-1:0] cand;
  logic          cand_found;
  logic [SW-1:0] sel;
  logic          sel_ok;
  logic [N-1:0]  sel_data;
  logic          sel_last;
  logic [SW-1:0] sel_next;
  logic          xfer;

  assign load = !out_valid_q || out_ready;

  // Scan from the far end back toward ptr so the nearest valid requester
  // (in modulo order from ptr) is the last one written and wins.
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (in_valid[idx]) begin
        cand       = SW'(idx);
        cand_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel      = (state_q == ST_LOCKED) ? gnt_q : cand;
    sel_ok   = (state_q == ST_LOCKED) ? 1'b1  : cand_found;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SW'(i) == sel) begin
        sel_data = in_data[i*N +: N];
        sel_last = in_last[i];
      end
    end
    sel_next = (sel == SW'(NUM_IN - 1)) ? '0 : sel + SW'(1);
  end

  // While locked, ready is offered to gnt even if it is not valid; only a
  // valid gnt word actually transfers.
  always_comb begin
    in_ready = '0;
    if (reset && sel_ok && load) in_ready[sel] = 1'b1;
  end

  assign xfer = reset && sel_ok && load && in_valid[sel];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = sel;
      out_last_d  = sel_last;
      if (sel_last) begin
        state_d = ST_IDLE;
        ptr_d   = sel_next;
      end else begin
        state_d = ST_LOCKED;
        gnt_d   = sel;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == ST_LOCKED) || out_valid_q;

endmodule

// File: tb/tb_bd_dn_arbiter.sv
// Directed bench for bd_dn_arbiter: NUM_IN=4 main instance plus a NUM_IN=3
// instance for wrap-around on a non-power-of-2 requester count.
module tb_bd_dn_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [3:0]  in_valid, in_ready, in_last;
  logic [83:0] in_data;
  logic        out_valid, out_ready, out_last, busy;
  logic [20:0] out_data;
  logic [1:0]  out_src;

  logic [2:0]  in_valid3, in_ready3, in_last3;
  logic [62:0] in_data3;
  logic        out_valid3, out_ready3, out_last3, busy3;
  logic [20:0] out_data3;
  logic [1:0]  out_src3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bd_dn_arbiter #(.NUM_IN(4), .N(21)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_last(out_last), .busy(busy)
  );

  bd_dn_arbiter #(.NUM_IN(3), .N(21)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_last(in_last3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_src(out_src3), .out_last(out_last3), .busy(busy3)
  );

  task automatic set_word(input int i, input logic [20:0] d, input logic l);
    in_data[i*21 +: 21] = d;
    in_last[i] = l;
  endtask

  task automatic do_reset();
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    in_valid3 = '0; in_last3 = '0; in_data3 = '0; out_ready3 = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) set_word(i, 21'h1000 + 21'(i), 1'b1);
    in_valid = 4'hF;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      failures++;
      $display("FAIL reset_pre_load valid=%b src=%0d exp valid=1 src=0", out_valid, out_src);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 21'h0 || out_src !== 2'd0 ||
        out_last !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_outputs valid=%b data=%h src=%0d last=%b busy=%b exp all 0",
               out_valid, out_data, out_src, out_last, busy);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=0001", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 21'h1000) begin
      failures++;
      $display("FAIL reset_first_winner valid=%b src=%0d data=%h exp 1/0/001000",
               out_valid, out_src, out_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_word(i, 21'h1000 + 21'(i), 1'b1);
    in_valid = 4'hF;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'(1 << (c % 4))) begin
        failures++;
        $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, in_ready, 4'(1 << (c % 4)));
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(c % 4) ||
          out_data !== 21'h1000 + 21'(c % 4) || out_last !== 1'b1) begin
        failures++;
        $display("FAIL rr_seq cyc=%0d valid=%b src=%0d data=%h exp src=%0d data=%h",
                 c, out_valid, out_src, out_data, c % 4, 21'h1000 + 21'(c % 4));
      end
    end
  endtask

  task automatic test_atomicity();
    do_reset();
    out_ready = 1'b1;
    set_word(0, 21'h1000, 1'b1);
    in_valid = 4'b0001;
    @(posedge clk); #1;
    checks++;
    if (out_src !== 2'd0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL atom_prime src=%0d valid=%b exp src=0 valid=1", out_src, out_valid);
    end
    set_word(1, 21'h0A, 1'b0);
    set_word(2, 21'h1002, 1'b1);
    set_word(3, 21'h1003, 1'b1);
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL atom_ready_idle got=%b exp=0010", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_src !== 2'd1 || out_data !== 21'h0A || out_last !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL atom_w0 src=%0d data=%h last=%b busy=%b exp 1/0A/0/1",
               out_src, out_data, out_last, busy);
    end
    set_word(1, 21'h0B, 1'b0);
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL atom_ready_locked got=%b exp=0010", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_src !== 2'd1 || out_data !== 21'h0B || out_last !== 1'b0) begin
      failures++;
      $display("FAIL atom_w1 src=%0d data=%h last=%b exp 1/0B/0", out_src, out_data, out_last);
    end
    set_word(1, 21'h0C, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (out_src !== 2'd1 || out_data !== 21'h0C || out_last !== 1'b1) begin
      failures++;
      $display("FAIL atom_w2 src=%0d data=%h last=%b exp 1/0C/1", out_src, out_data, out_last);
    end
    @(posedge clk); #1;
    checks++;
    if (out_src !== 2'd2 || out_data !== 21'h1002 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL atom_next src=%0d data=%h valid=%b exp 2/001002/1",
               out_src, out_data, out_valid);
    end
  endtask

  task automatic test_locked_stall();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_word(i, 21'h1000 + 21'(i), 1'b1);
    set_word(2, 21'h20, 1'b0);
    in_valid = 4'b0100;
    @(posedge clk); #1;
    checks++;
    if (out_src !== 2'd2 || out_data !== 21'h20 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_first src=%0d data=%h valid=%b exp 2/20/1", out_src, out_data, out_valid);
    end
    in_valid = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 4'b0100) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d valid=%b busy=%b ready=%b exp 0/1/0100",
                 c, out_valid, busy, in_ready);
      end
    end
    set_word(2, 21'h21, 1'b1);
    in_valid = 4'b1111;
    @(posedge clk); #1;
    checks++;
    if (out_src !== 2'd2 || out_data !== 21'h21 || out_last !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_resume src=%0d data=%h last=%b valid=%b exp 2/21/1/1",
               out_src, out_data, out_last, out_valid);
    end
    in_valid = 4'b1011;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL stall_after_ready got=%b exp=1000", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_src !== 2'd3 || out_data !== 21'h1003) begin
      failures++;
      $display("FAIL stall_after src=%0d data=%h exp 3/001003", out_src, out_data);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] pat;
    logic [23:0] pat_hi;
    logic [20:0] snap_data;
    logic [1:0]  snap_src;
    logic        snap_last;
    logic        hold;
    int          exp_next;
    int          consumed;
    pat = 24'b1011_0010_1110_0001_1101_0110;
    exp_next = 0;
    consumed = 0;
    do_reset();
    for (int i = 0; i < 4; i++) set_word(i, 21'h1000 + 21'(i), 1'b1);
    in_valid = 4'hF;
    for (int c = 0; c < 24; c++) begin
      out_ready = pat[c];
      #1;
      hold = out_valid && !out_ready;
      snap_data = out_data; snap_src = out_src; snap_last = out_last;
      if (hold) begin
        checks++;
        if (in_ready !== 4'b0000) begin
          failures++;
          $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_src !== 2'(exp_next) || out_data !== 21'h1000 + 21'(exp_next)) begin
          failures++;
          $display("FAIL bp_order cyc=%0d src=%0d data=%h exp src=%0d", c, out_src, out_data, exp_next);
        end
        exp_next = (exp_next + 1) % 4;
        consumed++;
      end
      @(posedge clk); #1;
      checks++;
      if (hold) begin
        if (out_valid !== 1'b1 || out_data !== snap_data || out_src !== snap_src ||
            out_last !== snap_last) begin
          failures++;
          $display("FAIL bp_stable cyc=%0d data=%h src=%0d exp data=%h src=%0d",
                   c, out_data, out_src, snap_data, snap_src);
        end
      end else if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_bubble cyc=%0d valid=%b exp=1", c, out_valid);
      end
    end
    pat_hi = pat;
    pat_hi[0] = 1'b0;
    checks++;
    if (consumed !== $countones(pat_hi)) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=%0d", consumed, $countones(pat_hi));
    end
    out_ready = 1'b1;
  endtask

  task automatic test_wrap();
    logic [1:0] exp_src;
    do_reset();
    in_data3[2*21 +: 21] = 21'h302;
    in_last3 = 3'b111;
    in_valid3 = 3'b100;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (in_ready3 !== 3'b100) begin
        failures++;
        $display("FAIL wrap_ready cyc=%0d got=%b exp=100", c, in_ready3);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid3 !== 1'b1 || out_src3 !== 2'd2 || out_data3 !== 21'h302 || out_last3 !== 1'b1) begin
        failures++;
        $display("FAIL wrap_single cyc=%0d valid=%b src=%0d data=%h exp 1/2/302",
                 c, out_valid3, out_src3, out_data3);
      end
    end
    in_data3[0 +: 21] = 21'h300;
    in_valid3 = 3'b101;
    for (int c = 0; c < 6; c++) begin
      exp_src = (c % 2 == 0) ? 2'd0 : 2'd2;
      @(posedge clk); #1;
      checks++;
      if (out_valid3 !== 1'b1 || out_src3 !== exp_src || out_src3 === 2'd3) begin
        failures++;
        $display("FAIL wrap_alt cyc=%0d src=%0d exp=%0d", c, out_src3, exp_src);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_atomicity();
    test_locked_stall();
    test_backpressure();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bd_dn_arbiter.md
# bd_dn_arbiter

Round-robin, packet-atomic arbiter that merges NUM_IN downstream word channels (config, memory programming, spike input) onto the single 21-bit downstream channel that feeds BDIfc's BD-bound path. Once a requester wins, it holds the grant until it sends a word flagged `last`. This keeps multi-word BD messages contiguous. The output is registered and sits directly in front of BDIfc in the core clock domain.

## Interface
Parameters:
- `NUM_IN`, default 4. Number of requesters; 2..16, need not be a power of 2.
- `N`, default 21. Word width; matches the BD downstream word.
- `SW`, default `$clog2(NUM_IN)`. Width of the source index.

Ports:
- `clk` input, 1. Core clock; all state updates on the rising edge.
- `reset` input, 1. Asynchronous, active-low. Low means in reset.
- `in_valid` input, NUM_IN. Per-requester valid.
- `in_ready` output, NUM_IN. Per-requester ready.
- `in_data` input, NUM_IN*N. Requester i occupies bits [i*N +: N].
- `in_last` input, NUM_IN. Qualified by `in_valid[i]`; marks the final word of a message.
- `out_valid` output, 1. Registered output valid.
- `out_ready` input, 1. Downstream (BDIfc) ready.
- `out_data` output, N. Registered word.
- `out_src` output, SW. Index of the requester that supplied `out_data`.
- `out_last` output, 1. Registered copy of the `in_last` of the word in `out_data`.
- `busy` output, 1. High when state is LOCKED or `out_valid` is high.

## Operation
State:
- FSM states IDLE and LOCKED.
- Registers `gnt` (SW bits), `ptr` (SW bits), and the output register (`out_valid`, `out_data`, `out_src`, `out_last`).

Output register:
- `load = !out_valid || out_ready`.
- A transfer from requester i occurs when `in_valid[i] && in_ready[i]`.

IDLE:
- The candidate is the first i with `in_valid[i]` high, scanning `ptr, ptr+1, …` modulo NUM_IN.
- `in_ready[cand] = load`; every other `in_ready` is 0.
- If no `in_valid` is high, all `in_ready` are 0 and the state is unchanged.

On a transfer from i in IDLE:
- The output register loads the word, with `out_src = i`.
- If `in_last[i]` is high: stay in IDLE and set `ptr = (i+1) mod NUM_IN`.
- Otherwise: go to LOCKED and set `gnt = i`.

LOCKED:
- `in_ready[gnt] = load`; all others are 0. No other requester is considered, however long `gnt` stays idle.
- On a transfer with `in_last` high: go to IDLE and set `ptr = (gnt+1) mod NUM_IN`.

Wrap-around:
- `ptr` and the scan wrap from NUM_IN-1 to 0.
- For a non-power-of-2 NUM_IN, indices ≥ NUM_IN are never produced.

Output register update:
- If a transfer occurs: load the word.
- Else if `out_ready` is high: clear `out_valid`.
- Otherwise: hold all output register contents.

Arbitration rules:
- Combinational `in_valid`/`in_ready` values are not registered. The inputs must obey valid/ready rules: once valid is high, data and `last` are held stable until accepted.
- No `in_valid` → `in_ready` dependency exists beyond the candidate scan.
- A requester may drop `in_valid` while it is the IDLE candidate without being accepted. The scan then moves on in the same cycle.

## Timing
- Reset (reset low, asynchronous): `out_valid=0`, `out_data=0`, `out_src=0`, `out_last=0`, `busy=0`, state IDLE, `ptr=0`, `gnt=0`.
- All `in_ready` are 0 while reset is low.
- Deassertion takes effect at the first `clk` edge after reset goes high.

Latency and throughput:
- Latency is 1 cycle: a word accepted at edge t is presented on `out_*` from edge t until it is consumed.
- Throughput is 1 word/cycle while `out_ready` is held high, including across packet boundaries and grant changes. There are no bubbles on arbitration.

Backpressure and boundary cases:
- Backpressure: with `out_valid` high and `out_ready` low, all `in_ready` are 0 and the output register holds.
- The combinational path `out_ready → in_ready` is permitted.
- Simultaneous requests: exactly one requester is accepted per cycle, the first from `ptr` in scan order.
- `in_last` high on the first word gives a single-word message. The FSM never enters LOCKED.
- Reset mid-message: the partial message is discarded. The next grant starts from `ptr=0`.

## Test plan
- **Reset:** assert reset low asynchronously mid-cycle while `out_valid` is high → all outputs 0 immediately, `in_ready` all 0. After release with `in_valid=4'b1111` and `out_ready=1`, the first winner is `out_src=0`.
- **Round-robin fairness:** NUM_IN=4, all requesters send single-word messages with data=0x1000+i continuously, `out_ready=1` → `out_src` sequence is 0,1,2,3,0,1,… at 1 word/cycle with no idle cycles.
- **Atomicity:** requester 1 sends 3 words (0x0A,0x0B,0x0C, `last` on the third) while requesters 0, 2 and 3 are valid → output is 0x0A,0x0B,0x0C from src 1 contiguously, then src 2 next.
- **Locked stall:** requester 2 goes idle for 5 cycles mid-message while the others are valid → `out_valid` falls after the last word drains, no other source is granted, and the message resumes from src 2.
- **Backpressure:** toggle `out_ready` randomly at 50% with random sources and lengths → scoreboard shows no loss, duplication or reordering per source, and `out_data`/`out_src`/`out_last` stay stable while `out_valid && !out_ready`.
- **Wrap and non-power-of-2:** NUM_IN=3 with only requester 2 valid, single-word messages → `ptr` wraps 2→0, src 2 is re-granted every cycle, and `out_src` is never 3.
